video_format_reporter: RTL and testbench
========================================

VIDEO_FORMAT_REPORTER -- requirements
Module: video_format_reporter

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 50000, meaning clocks between format samples (1 ms at 50 MHz).
REQ-002 SHALL have parameter STABLE_COUNT, default 8, meaning identical consecutive samples needed to qualify a code.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 5000000, meaning clocks allowed for host_ack to rise (100 ms).
REQ-004 SHALL have port clk_50mhz_in, input, 1 bit, the single 50 MHz clock.
REQ-005 SHALL have port reset_x, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port format_in, input, 8 bits, raw BVM format code from the detector, asynchronous to clk_50mhz_in.
REQ-007 SHALL have port host_ack, input, 1 bit, host acknowledge, asynchronous.
REQ-008 SHALL have port format_out, output, 8 bits, qualified format code reported to the host.
REQ-009 SHALL have port format_valid, output, 1 bit, high when the reported code is nonzero and current.
REQ-010 SHALL have port change_req, output, 1 bit, 4-phase change request to the host.
REQ-011 SHALL have port timeout_err, output, 1 bit, sticky ack-timeout flag.

Function
REQ-012 SHALL pass format_in and host_ack through 2-flop synchronizers; multi-bit skew is absorbed by REQ-014.
REQ-013 SHALL generate a one-cycle sample tick every SAMPLE_DIV clocks from a free-running counter that wraps from SAMPLE_DIV-1 to 0.
REQ-014 On each tick: if the synced sample equals the candidate, stable_cnt increments, saturating at STABLE_COUNT; otherwise candidate takes the sample and stable_cnt is set to 1.
REQ-015 A code SHALL be qualified when stable_cnt == STABLE_COUNT and the candidate differs from format_out.
REQ-016 SHALL implement FSM states IDLE, REQ and RELEASE.
REQ-017 IDLE: on a qualified code, or with pending set on a tick, format_out takes the candidate, pending is set, change_req goes high and the FSM enters REQ on the same edge.
REQ-018 REQ: change_req is held high; on synced host_ack = 1, the FSM clears pending, clears timeout_err, drops change_req and enters RELEASE.
REQ-019 REQ: if ACK_TIMEOUT clocks elapse without ack, the FSM drops change_req, sets timeout_err and returns to IDLE with pending still set, so the request is retried per REQ-017.
REQ-020 RELEASE: the FSM waits for synced host_ack = 0, then enters IDLE; there is no timeout in RELEASE.
REQ-021 Codes qualified while in REQ or RELEASE SHALL NOT alter format_out; they are re-evaluated once the FSM is back in IDLE.
REQ-022 format_valid SHALL equal (format_out != 0) AND NOT pending.
REQ-023 Counter widths SHALL be $clog2(parameter+1); no counter SHALL wrap except the sample counter.

Reset
REQ-024 While reset_x = 0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the counters, candidate, stable_cnt and pending SHALL be 0; this holds even mid-handshake.
REQ-025 After reset release, the first request SHALL occur no earlier than STABLE_COUNT ticks later.

Configuration
REQ-026 With FORMAT_HOLD_EN defined, a qualified code 0 SHALL leave format_out unchanged, clear format_valid and issue no request; the next nonzero qualified code SHALL be reported normally.
REQ-027 Without FORMAT_HOLD_EN, code 0 SHALL be treated like any other code: format_out becomes 0 and a request is issued.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the FMT_NONE = 8'h00 constant and the default timing constants.
REQ-029 The synchronizer SHALL be one sub-module, sync_2ff, parameterized by width and instantiated for format_in and host_ack.

Verification (bench uses SAMPLE_DIV=4, STABLE_COUNT=3, ACK_TIMEOUT=20)
REQ-030 Hold format_in=8'h03 after reset with ack echoing req -> format_out=03 and change_req rises within 3 ticks plus 3 clocks; format_valid=1 after ack.
REQ-031 Toggle format_in 03/12 on every tick -> no request and format_out unchanged.
REQ-032 Qualify 8'h13 with host_ack held 0 -> change_req drops after 20 clocks, timeout_err=1, re-request on the next tick; a later ack clears timeout_err.
REQ-033 Change format_in to 8'h01 while in REQ for 8'h04 -> 04 is completed first, then 01 is requested after return to IDLE.
REQ-034 Apply format_in=0 after 8'h0B: with FORMAT_HOLD_EN, format_out=0B, format_valid=0 and no request; without it, format_out=00 and a request is issued.
REQ-035 Assert reset_x low while in REQ -> change_req, format_out and timeout_err are 0 immediately, and the FSM is in IDLE.

Source files
------------

// File: rtl/video_format_reporter_pkg.sv
// Shared types and constants for the video format reporter.
// Optional feature macro used by the top: FORMAT_HOLD_EN.
package video_format_reporter_pkg;

  // Width of a BVM format code
  localparam int unsigned FMT_W = 8;

  // Code meaning "no format"
  localparam logic [FMT_W-1:0] FMT_NONE = 8'h00;

  // Default timing at 50 MHz: 1 ms sample period, 8 stable samples, 100 ms ack window
  localparam int unsigned DEF_SAMPLE_DIV   = 50000;
  localparam int unsigned DEF_STABLE_COUNT = 8;
  localparam int unsigned DEF_ACK_TIMEOUT  = 5000000;

  // Host handshake FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Reported code is usable by the host: nonzero, acknowledged and not parked on a held zero
  function automatic logic fmt_is_valid(input logic [FMT_W-1:0] fmt,
                                        input logic             pending,
                                        input logic             zero_held);
    return (fmt != FMT_NONE) && !pending && !zero_held;
  endfunction

endpackage

// File: rtl/video_format_reporter_sync_2ff.sv
// Two-flop synchronizer for signals entering the clk domain.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_x,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Metastability stage followed by the stable output stage
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/video_format_reporter.sv
// Video format reporter: qualifies the raw detector format code by repeated
// sampling and reports changes to the host over a 4-phase req/ack handshake.
// Build option: define FORMAT_HOLD_EN to keep the last nonzero code on the
// output when the detector reports code 0 (no request, format_valid cleared).
module video_format_reporter
  import video_format_reporter_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV   = DEF_SAMPLE_DIV,
  parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int unsigned ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
  input  logic       clk_50mhz_in,
  input  logic       reset_x,
  input  logic [7:0] format_in,
  input  logic       host_ack,
  output logic [7:0] format_out,
  output logic       format_valid,
  output logic       change_req,
  output logic       timeout_err
);

  localparam int unsigned SAMP_W = $clog2(SAMPLE_DIV + 1);
  localparam int unsigned STAB_W = $clog2(STABLE_COUNT + 1);
  localparam int unsigned ACK_W  = $clog2(ACK_TIMEOUT + 1);

  logic [FMT_W-1:0]  fmt_sync;
  logic              ack_sync;

  logic [SAMP_W-1:0] samp_cnt;
  logic              tick_c;

  logic [FMT_W-1:0]  candidate;
  logic [STAB_W-1:0] stable_cnt;
  logic              stable_full_c;
  logic              qualified_c;
  logic              hold_zero_c;
  logic              restore_c;

  state_t            state;
  state_t            state_nxt;
  logic              pending;
  logic              pending_nxt;
  logic              zero_held;
  logic              zero_held_nxt;
  logic [ACK_W-1:0]  ack_cnt;
  logic [ACK_W-1:0]  ack_cnt_nxt;
  logic [FMT_W-1:0]  format_out_nxt;
  logic              format_valid_nxt;
  logic              change_req_nxt;
  logic              timeout_err_nxt;

  sync_2ff #(.WIDTH(FMT_W)) u_sync_fmt (
    .clk     (clk_50mhz_in),
    .reset_x (reset_x),
    .d       (format_in),
    .q       (fmt_sync)
  );

  sync_2ff #(.WIDTH(1)) u_sync_ack (
    .clk     (clk_50mhz_in),
    .reset_x (reset_x),
    .d       (host_ack),
    .q       (ack_sync)
  );

  // Free-running sample divider; the tick marks its last count
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      samp_cnt <= '0;
    end else if (samp_cnt == SAMP_W'(SAMPLE_DIV - 1)) begin
      samp_cnt <= '0;
    end else begin
      samp_cnt <= samp_cnt + SAMP_W'(1);
    end
  end

  assign tick_c = (samp_cnt == SAMP_W'(SAMPLE_DIV - 1));

  // Candidate tracking: count identical consecutive samples, restart on any difference
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      candidate  <= FMT_NONE;
      stable_cnt <= '0;
    end else if (tick_c) begin
      if (fmt_sync == candidate) begin
        if (stable_cnt != STAB_W'(STABLE_COUNT)) begin
          stable_cnt <= stable_cnt + STAB_W'(1);
        end
      end else begin
        candidate  <= fmt_sync;
        stable_cnt <= STAB_W'(1);
      end
    end
  end

  assign stable_full_c = (stable_cnt == STAB_W'(STABLE_COUNT));
  assign qualified_c   = stable_full_c && (candidate != format_out);

`ifdef FORMAT_HOLD_EN
  // A qualified zero parks the output instead of being reported
  assign hold_zero_c = (candidate == FMT_NONE);
`else
  assign hold_zero_c = 1'b0;
`endif

  // Detector returned to the code already on the output while parked on zero
  assign restore_c = zero_held && stable_full_c && (candidate == format_out) &&
                     (candidate != FMT_NONE);

  // FSM and output registers
  always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
    if (!reset_x) begin
      state        <= ST_IDLE;
      pending      <= 1'b0;
      zero_held    <= 1'b0;
      ack_cnt      <= '0;
      format_out   <= FMT_NONE;
      format_valid <= 1'b0;
      change_req   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      pending      <= pending_nxt;
      zero_held    <= zero_held_nxt;
      ack_cnt      <= ack_cnt_nxt;
      format_out   <= format_out_nxt;
      format_valid <= format_valid_nxt;
      change_req   <= change_req_nxt;
      timeout_err  <= timeout_err_nxt;
    end
  end

  // Next-state and output logic for the host handshake
  always_comb begin
    state_nxt       = state;
    pending_nxt     = pending;
    zero_held_nxt   = zero_held;
    ack_cnt_nxt     = '0;
    format_out_nxt  = format_out;
    change_req_nxt  = change_req;
    timeout_err_nxt = timeout_err;

    case (state)
      ST_IDLE: begin
        change_req_nxt = 1'b0;
        if ((qualified_c && !hold_zero_c) || (pending && tick_c)) begin
          // A retry with a parked zero candidate re-announces the held code
          if (!hold_zero_c) begin
            format_out_nxt = candidate;
          end
          zero_held_nxt  = 1'b0;
          pending_nxt    = 1'b1;
          change_req_nxt = 1'b1;
          state_nxt      = ST_REQ;
        end else if (qualified_c) begin
          zero_held_nxt = 1'b1;
        end else if (restore_c) begin
          zero_held_nxt = 1'b0;
        end
      end

      ST_REQ: begin
        if (ack_sync) begin
          pending_nxt     = 1'b0;
          timeout_err_nxt = 1'b0;
          change_req_nxt  = 1'b0;
          state_nxt       = ST_RELEASE;
        end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
          // Give up this attempt; pending stays set so IDLE retries on a tick
          change_req_nxt  = 1'b0;
          timeout_err_nxt = 1'b1;
          state_nxt       = ST_IDLE;
        end else begin
          ack_cnt_nxt = ack_cnt + ACK_W'(1);
        end
      end

      ST_RELEASE: begin
        change_req_nxt = 1'b0;
        if (!ack_sync) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        change_req_nxt = 1'b0;
        state_nxt      = ST_IDLE;
      end
    endcase

    format_valid_nxt = fmt_is_valid(format_out_nxt, pending_nxt, zero_held_nxt);
  end

endmodule

// File: tb/tb_video_format_reporter.sv
// Self-checking bench for video_format_reporter (SAMPLE_DIV=4, STABLE_COUNT=3,
// ACK_TIMEOUT=20). A host model answers the 4-phase handshake with random
// latency; expectations come from the qualification rules applied to the
// stimulus. Build option FORMAT_HOLD_EN selects the held-zero expectations.
module tb_video_format_reporter;

  localparam int unsigned SD = 4;
  localparam int unsigned SC = 3;
  localparam int unsigned AT = 20;

  logic       clk = 1'b0;
  logic       reset_x = 1'b0;
  logic [7:0] format_in = 8'h00;
  logic       host_ack = 1'b0;
  logic [7:0] format_out;
  logic       format_valid;
  logic       change_req;
  logic       timeout_err;

  int         vectors = 0;
  int         miscompares = 0;

  // Host model controls and request monitor
  bit         auto_ack = 1'b0;
  logic       manual_ack = 1'b0;
  int         req_rises = 0;
  logic       req_q = 1'b0;

  // Last code the host is expected to hold
  logic [7:0] exp_fmt = 8'h00;

  video_format_reporter #(
    .SAMPLE_DIV   (SD),
    .STABLE_COUNT (SC),
    .ACK_TIMEOUT  (AT)
  ) dut (
    .clk_50mhz_in (clk),
    .reset_x      (reset_x),
    .format_in    (format_in),
    .host_ack     (host_ack),
    .format_out   (format_out),
    .format_valid (format_valid),
    .change_req   (change_req),
    .timeout_err  (timeout_err)
  );

  always #10 clk = ~clk;

  // Host: count requests and echo change_req with random latency (or follow manual_ack)
  always @(negedge clk) begin
    if (change_req === 1'b1 && req_q !== 1'b1) req_rises++;
    req_q = change_req;
    if (!auto_ack) host_ack = manual_ack;
    else if (host_ack !== change_req && $urandom_range(0, 1) == 0) host_ack = change_req;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req(input logic level, input int budget, output int cycles);
    cycles = 0;
    while (change_req !== level && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    reset_x    = 1'b0;
    format_in  = 8'h03;
    step(3);
    vectors++;
    if (format_out !== 8'h00) begin
      miscompares++; $display("FAIL reset_format_out: got %h want 00", format_out);
    end
    vectors++;
    if (format_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_format_valid: got %b want 0", format_valid);
    end
    vectors++;
    if (change_req !== 1'b0) begin
      miscompares++; $display("FAIL reset_change_req: got %b want 0", change_req);
    end
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err);
    end
  endtask

  task automatic test_first_request();
    int cyc;
    auto_ack = 1'b1;
    @(negedge clk);
    reset_x = 1'b1;
    wait_req(1'b1, 30, cyc);
    vectors++;
    if (change_req !== 1'b1 || cyc < int'((SC - 1) * SD + 1) || cyc > int'(SC * SD + 3)) begin
      miscompares++;
      $display("FAIL first_req_latency: req=%b after %0d clocks want 1 within %0d..%0d",
               change_req, cyc, (SC - 1) * SD + 1, SC * SD + 3);
    end
    vectors++;
    if (format_out !== 8'h03) begin
      miscompares++; $display("FAIL first_req_format_out: got %h want 03", format_out);
    end
    wait_req(1'b0, 30, cyc);
    step(8);
    vectors++;
    if (format_valid !== 1'b1 || change_req !== 1'b0) begin
      miscompares++;
      $display("FAIL first_req_valid: valid=%b req=%b want valid=1 req=0", format_valid, change_req);
    end
    exp_fmt = 8'h03;
  endtask

  task automatic test_toggle();
    int base;
    base = req_rises;
    for (int i = 0; i < 12; i++) begin
      format_in = (i % 2 == 0) ? 8'h12 : 8'h03;
      step(SD);
    end
    format_in = 8'h03;
    step(5 * SD);
    vectors++;
    if (req_rises - base != 0) begin
      miscompares++; $display("FAIL toggle_requests: got %0d want 0", req_rises - base);
    end
    vectors++;
    if (format_out !== exp_fmt || format_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL toggle_format_out: got %h valid=%b want %h valid=1", format_out, format_valid, exp_fmt);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    int high;
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    step(2);
    format_in = 8'h13;
    wait_req(1'b1, 40, cyc);
    vectors++;
    if (change_req !== 1'b1 || format_out !== 8'h13) begin
      miscompares++;
      $display("FAIL timeout_first_req: req=%b out=%h want req=1 out=13", change_req, format_out);
    end
    high = 0;
    while (change_req === 1'b1 && high < 40) begin
      step(1);
      high++;
    end
    vectors++;
    if (high != int'(AT)) begin
      miscompares++; $display("FAIL timeout_req_width: got %0d clocks want %0d", high, AT);
    end
    vectors++;
    if (timeout_err !== 1'b1 || format_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_flag: err=%b valid=%b want err=1 valid=0", timeout_err, format_valid);
    end
    wait_req(1'b1, SD + 2, cyc);
    vectors++;
    if (change_req !== 1'b1 || format_out !== 8'h13) begin
      miscompares++;
      $display("FAIL timeout_retry: req=%b out=%h after %0d clocks want req=1 out=13", change_req, format_out, cyc);
    end
    auto_ack = 1'b1;
    wait_req(1'b0, 30, cyc);
    step(8);
    vectors++;
    if (timeout_err !== 1'b0 || format_valid !== 1'b1 || format_out !== 8'h13) begin
      miscompares++;
      $display("FAIL timeout_ack_clears: err=%b valid=%b out=%h want 0 1 13", timeout_err, format_valid, format_out);
    end
    exp_fmt = 8'h13;
  endtask

  task automatic test_back_to_back();
    int cyc;
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    step(2);
    format_in = 8'h04;
    wait_req(1'b1, 40, cyc);
    vectors++;
    if (change_req !== 1'b1 || format_out !== 8'h04) begin
      miscompares++;
      $display("FAIL b2b_first_req: req=%b out=%h want req=1 out=04", change_req, format_out);
    end
    format_in = 8'h01;
    step(14);
    vectors++;
    if (change_req !== 1'b1 || format_out !== 8'h04) begin
      miscompares++;
      $display("FAIL b2b_in_req: req=%b out=%h want req=1 out=04", change_req, format_out);
    end
    manual_ack = 1'b1;
    wait_req(1'b0, 10, cyc);
    vectors++;
    if (change_req !== 1'b0 || format_out !== 8'h04) begin
      miscompares++;
      $display("FAIL b2b_complete: req=%b out=%h want req=0 out=04", change_req, format_out);
    end
    manual_ack = 1'b0;
    wait_req(1'b1, 40, cyc);
    vectors++;
    if (change_req !== 1'b1 || format_out !== 8'h01) begin
      miscompares++;
      $display("FAIL b2b_second_req: req=%b out=%h want req=1 out=01", change_req, format_out);
    end
    auto_ack = 1'b1;
    wait_req(1'b0, 30, cyc);
    step(8);
    vectors++;
    if (format_valid !== 1'b1 || format_out !== 8'h01) begin
      miscompares++;
      $display("FAIL b2b_final: valid=%b out=%h want 1 01", format_valid, format_out);
    end
    exp_fmt = 8'h01;
  endtask

  task automatic test_zero();
    int cyc;
    int base;
    auto_ack  = 1'b1;
    format_in = 8'h0B;
    wait_req(1'b1, 40, cyc);
    vectors++;
    if (change_req !== 1'b1 || format_out !== 8'h0B) begin
      miscompares++;
      $display("FAIL zero_setup_req: req=%b out=%h want req=1 out=0b", change_req, format_out);
    end
    wait_req(1'b0, 30, cyc);
    step(8);
    vectors++;
    if (format_valid !== 1'b1) begin
      miscompares++; $display("FAIL zero_setup_valid: got %b want 1", format_valid);
    end
    base = req_rises;
    format_in = 8'h00;
    step(50);
`ifdef FORMAT_HOLD_EN
    vectors++;
    if (req_rises - base != 0) begin
      miscompares++; $display("FAIL zero_hold_requests: got %0d want 0", req_rises - base);
    end
    vectors++;
    if (format_out !== 8'h0B || format_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_hold_output: out=%h valid=%b want 0b 0", format_out, format_valid);
    end
    exp_fmt = 8'h0B;
`else
    vectors++;
    if (req_rises - base != 1) begin
      miscompares++; $display("FAIL zero_requests: got %0d want 1", req_rises - base);
    end
    vectors++;
    if (format_out !== 8'h00 || format_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_output: out=%h valid=%b want 00 0", format_out, format_valid);
    end
    exp_fmt = 8'h00;
`endif
  endtask

  task automatic test_random();
    logic [7:0] code;
    int base;
    auto_ack = 1'b1;
    for (int r = 0; r < 8; r++) begin
      do code = 8'($urandom_range(1, 255)); while (code == exp_fmt);
      base = req_rises;
      // A short glitch is seen by at most SC-1 ticks and must never be reported
      format_in = 8'($urandom_range(1, 255));
      step(int'($urandom_range(1, SD * (SC - 1) - 1)));
      format_in = code;
      step(int'($urandom_range(60, 80)));
      vectors++;
      if (req_rises - base != 1) begin
        miscompares++; $display("FAIL rand_requests[%0d]: got %0d want 1", r, req_rises - base);
      end
      vectors++;
      if (format_out !== code || format_valid !== 1'b1 || change_req !== 1'b0 || timeout_err !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_state[%0d]: out=%h valid=%b req=%b err=%b want %h 1 0 0",
                 r, format_out, format_valid, change_req, timeout_err, code);
      end
      exp_fmt = code;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] code;
    int cyc;
    auto_ack   = 1'b0;
    manual_ack = 1'b0;
    step(2);
    do code = 8'($urandom_range(1, 255)); while (code == exp_fmt);
    format_in = code;
    wait_req(1'b1, 40, cyc);
    step(AT + 2);
    wait_req(1'b1, SD + 2, cyc);
    vectors++;
    if (change_req !== 1'b1 || timeout_err !== 1'b1 || format_out !== code) begin
      miscompares++;
      $display("FAIL midreset_setup: req=%b err=%b out=%h want 1 1 %h", change_req, timeout_err, format_out, code);
    end
    @(negedge clk);
    reset_x = 1'b0;
    #1;
    vectors++;
    if (change_req !== 1'b0 || format_out !== 8'h00 || timeout_err !== 1'b0 || format_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: req=%b out=%h err=%b valid=%b want all 0",
               change_req, format_out, timeout_err, format_valid);
    end
    step(3);
    @(negedge clk);
    reset_x = 1'b1;
    wait_req(1'b1, 30, cyc);
    vectors++;
    if (change_req !== 1'b1 || cyc < int'((SC - 1) * SD + 1)) begin
      miscompares++;
      $display("FAIL midreset_rerequest: req=%b after %0d clocks want 1 after at least %0d",
               change_req, cyc, (SC - 1) * SD + 1);
    end
    auto_ack = 1'b1;
    wait_req(1'b0, 30, cyc);
    step(8);
    vectors++;
    if (format_out !== code || format_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_final: out=%h valid=%b want %h 1", format_out, format_valid, code);
    end
  endtask

  initial begin
    test_reset();
    test_first_request();
    test_toggle();
    test_timeout();
    test_back_to_back();
    test_zero();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
